// File: rtl/kyber_pkg.sv
// Shared Kyber constants and small elaboration helpers used by the arithmetic
// sharing units (arbiters, tag pipes) around the NTT datapath.
package kyber_pkg;

   localparam int KYBER_Q     = 3329;
   localparam int COEFF_W     = 12;
   localparam int SUB_LATENCY = 3;

   // Index width that stays at least one bit wide, so single-bit selects remain legal.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning upward from ptr+1,
// wrapping modulo N. Purely combinational; the owner keeps the pointer register.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N <= 2) ? 1 : $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic any_req;

   assign any_req = |req;

   always_comb begin
      // NOTE: every output gets a default before any conditional write, so no latch is inferred.
      gnt     = '0;
      gnt_idx = ptr;
      // Lowest requester overall is the wrap-around candidate; a lowest one above ptr overrides it.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) gnt_idx = IW'(i);
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i] && (IW'(i) > ptr)) gnt_idx = IW'(i);
      end
      if (any_req) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/mod_sub_arbiter.sv
// Shares one pipelined modular subtractor between NUM_REQ butterfly lanes: round-robin
// issue, a tag pipe tracking ownership through the subtractor, and drain/idle control.
module mod_sub_arbiter
   import kyber_pkg::*;
#(
   parameter int DATA_WIDTH  = COEFF_W,
   parameter int MODULUS     = KYBER_Q,
   parameter int NUM_REQ     = 2,
   parameter int SUB_LATENCY = kyber_pkg::SUB_LATENCY
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          sub_enable,
   output logic                          sub_valid_in,
   output logic [DATA_WIDTH-1:0]         sub_a,
   output logic [DATA_WIDTH-1:0]         sub_b,
   input  logic [DATA_WIDTH-1:0]         sub_result,
   input  logic                          sub_valid_out,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic                          idle,
   output logic                          err_orphan
);

   localparam int TAG_W = clog2_min1(NUM_REQ);
   // Holds the worst case: SUB_LATENCY+1 ops in the pipe plus one whose strobe is pending.
   localparam int CNT_W = clog2_min1(SUB_LATENCY + 3);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("mod_sub_arbiter: NUM_REQ must be within 2..8");
   end
   if (MODULUS < 2 || MODULUS >= (1 << DATA_WIDTH)) begin : g_bad_modulus
      $error("mod_sub_arbiter: MODULUS does not fit DATA_WIDTH");
   end

   logic [NUM_REQ-1:0]    req_eff;
   logic [NUM_REQ-1:0]    gnt;
   logic [TAG_W-1:0]      gnt_idx;
   logic                  hs;

   logic [TAG_W-1:0]      ptr_q, ptr_d;
   logic                  sub_enable_q, sub_enable_d;
   logic                  sub_valid_in_q, sub_valid_in_d;
   logic [DATA_WIDTH-1:0] sub_a_q, sub_a_d;
   logic [DATA_WIDTH-1:0] sub_b_q, sub_b_d;
   logic [TAG_W-1:0]      issue_tag_q, issue_tag_d;

   logic [SUB_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [TAG_W-1:0]       tag_q [SUB_LATENCY];
   logic [TAG_W-1:0]       tag_d [SUB_LATENCY];
   logic                   tag_vld_out;
   logic [TAG_W-1:0]       tag_out;

   logic                  retire_q, retire_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                  err_orphan_q, err_orphan_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // sub_enable_q doubles as "unit out of reset", keeping req_ready low during and right after reset.
   assign req_eff = req_valid & {NUM_REQ{enable & sub_enable_q}};

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (TAG_W)
   ) u_rr (
      .req     (req_eff),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign hs = |gnt;

   always_comb begin
      ptr_d          = ptr_q;
      sub_enable_d   = 1'b1;
      sub_valid_in_d = hs;
      sub_a_d        = sub_a_q;
      sub_b_d        = sub_b_q;
      issue_tag_d    = issue_tag_q;
      if (hs) begin
         ptr_d       = gnt_idx;
         sub_a_d     = req_a[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
         sub_b_d     = req_b[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
         issue_tag_d = gnt_idx;
      end
   end

   // Tag stage 0 is loaded alongside sub_valid_in, so the last stage lines up with sub_valid_out.
   always_comb begin
      tag_vld_d[0] = sub_valid_in_q;
      tag_d[0]     = issue_tag_q;
      for (int i = 1; i < SUB_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_d[i]     = tag_q[i-1];
      end
   end

   assign tag_vld_out = tag_vld_q[SUB_LATENCY-1];
   assign tag_out     = tag_q[SUB_LATENCY-1];

   always_comb begin
      rsp_valid_d  = '0;
      rsp_result_d = rsp_result_q;
      retire_d     = tag_vld_out;
      err_orphan_d = err_orphan_q | (sub_valid_out ^ tag_vld_out);
      if (sub_valid_out && tag_vld_out) begin
         rsp_valid_d[tag_out] = 1'b1;
         rsp_result_d         = sub_result;
      end
   end

   // An op leaves the count when its response strobe has been issued, so idle trails the last strobe.
   always_comb begin
      cnt_d = cnt_q;
      if (hs && !retire_q)      cnt_d = cnt_q + CNT_W'(1);
      else if (!hs && retire_q) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q          <= TAG_W'(NUM_REQ - 1);
         sub_enable_q   <= 1'b0;
         sub_valid_in_q <= 1'b0;
         sub_a_q        <= '0;
         sub_b_q        <= '0;
         issue_tag_q    <= '0;
         // NOTE: the tag pipe is reset as a whole; an op in flight at reset must never surface afterwards.
         tag_vld_q      <= '0;
         for (int i = 0; i < SUB_LATENCY; i++) tag_q[i] <= '0;
         retire_q       <= 1'b0;
         rsp_valid_q    <= '0;
         rsp_result_q   <= '0;
         err_orphan_q   <= 1'b0;
         cnt_q          <= '0;
      end else begin
         // NOTE: non-blocking updates make every flop sample its _d from the same pre-edge state.
         ptr_q          <= ptr_d;
         sub_enable_q   <= sub_enable_d;
         sub_valid_in_q <= sub_valid_in_d;
         sub_a_q        <= sub_a_d;
         sub_b_q        <= sub_b_d;
         issue_tag_q    <= issue_tag_d;
         tag_vld_q      <= tag_vld_d;
         for (int i = 0; i < SUB_LATENCY; i++) tag_q[i] <= tag_d[i];
         retire_q       <= retire_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_result_q   <= rsp_result_d;
         err_orphan_q   <= err_orphan_d;
         cnt_q          <= cnt_d;
      end
   end

   assign req_ready    = gnt;
   assign sub_enable   = sub_enable_q;
   assign sub_valid_in = sub_valid_in_q;
   assign sub_a        = sub_a_q;
   assign sub_b        = sub_b_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_result   = rsp_result_q;
   assign idle         = (cnt_q == '0) && !sub_valid_in_q;
   assign err_orphan   = err_orphan_q;

endmodule
